window_gen_3x3: RTL and testbench

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

---
 rtl/window_gen_3x3.sv | 98 +++++++++
 tb/tb_window_gen_3x3.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers plus a two-column shift register feed a registered window.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pixel_i,
  input  logic        pixel_valid_i,
  input  logic        sof_i,
  output logic [71:0] window_o,
  output logic        window_valid_o,
  output logic        frame_done_o
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  logic [CW-1:0] c_q, c_d, eff_c;
  logic [RW-1:0] r_q, r_d, eff_r;
  logic [71:0]   win_q, win_d;
  logic          wv_q, wv_d;
  logic          fd_q, fd_d;

  // lb0 holds row r-1, lb1 holds row r-2, both indexed by column
  logic [7:0]    lb0_q [IMG_WIDTH];
  logic [7:0]    lb1_q [IMG_WIDTH];
  logic [23:0]   col1_q, col2_q;
  logic [23:0]   cur;
  logic          emit;

  always_comb begin
    eff_c = sof_i ? '0 : c_q;
    eff_r = sof_i ? '0 : r_q;
    cur   = {lb1_q[eff_c], lb0_q[eff_c], pixel_i};
    emit  = pixel_valid_i && (eff_r >= R_TWO) && (eff_c >= C_TWO);
  end

  always_comb begin
    c_d  = c_q;
    r_d  = r_q;
    win_d = win_q;
    wv_d = 1'b0;
    fd_d = 1'b0;
    if (pixel_valid_i) begin
      if (eff_c == C_LAST) begin
        c_d = '0;
        r_d = (eff_r == R_LAST) ? '0 : eff_r + RW'(1);
      end else begin
        c_d = eff_c + CW'(1);
        r_d = eff_r;
      end
      if (emit) begin
        wv_d  = 1'b1;
        fd_d  = (eff_r == R_LAST) && (eff_c == C_LAST);
        win_d = {col2_q[23:16], col1_q[23:16], cur[23:16],
                 col2_q[15:8],  col1_q[15:8],  cur[15:8],
                 col2_q[7:0],   col1_q[7:0],   cur[7:0]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      r_q   <= '0;
      win_q <= '0;
      wv_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      c_q   <= c_d;
      r_q   <= r_d;
      win_q <= win_d;
      wv_q  <= wv_d;
      fd_q  <= fd_d;
    end
  end

  // Storage is never read before being rewritten within the current frame
  always_ff @(posedge clk) begin
    if (pixel_valid_i) begin
      lb1_q[eff_c] <= lb0_q[eff_c];
      lb0_q[eff_c] <= pixel_i;
      col2_q       <= col1_q;
      col1_q       <= cur;
    end
  end

  assign window_o       = win_q;
  assign window_valid_o = wv_q;
  assign frame_done_o   = fd_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomized and directed bench for window_gen_3x3 (4x4 image).
// A raster-image reference model predicts every output cycle by cycle.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pixel_i = '0;
  logic        pixel_valid_i = 1'b0;
  logic        sof_i = 1'b0;
  logic [71:0] window_o;
  logic        window_valid_o;
  logic        frame_done_o;

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixel_i       (pixel_i),
    .pixel_valid_i (pixel_valid_i),
    .sof_i         (sof_i),
    .window_o      (window_o),
    .window_valid_o(window_valid_o),
    .frame_done_o  (frame_done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          mr, mc;
  logic [7:0]  img [H][W];
  logic [71:0] exp_win;
  logic        exp_v, exp_d;
  logic [71:0] seen [$];
  int          n_fd;

  task automatic chk(string tag, logic [71:0] got, logic [71:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic logic [71:0] lit(int b);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], 8'(b + i * W + j)};
    return w;
  endfunction

  task automatic model_reset();
    mr = 0; mc = 0;
    exp_v = 1'b0; exp_d = 1'b0; exp_win = '0;
  endtask

  task automatic model_step(bit v, bit s, logic [7:0] p);
    exp_v = 1'b0;
    exp_d = 1'b0;
    if (!v) return;
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      exp_v = 1'b1;
      exp_d = (mr == H - 1) && (mc == W - 1);
      exp_win = '0;
      for (int i = -2; i <= 0; i++)
        for (int j = -2; j <= 0; j++)
          exp_win = {exp_win[63:0], img[mr + i][mc + j]};
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic cyc(bit v, bit s, logic [7:0] p);
    pixel_valid_i = v;
    sof_i = s;
    pixel_i = p;
    model_step(v, s, p);
    @(posedge clk);
    @(negedge clk);
    chk("valid", 72'(window_valid_o), 72'(exp_v));
    chk("done", 72'(frame_done_o), 72'(exp_d));
    chk("window", window_o, exp_win);
    if (window_valid_o) seen.push_back(window_o);
    if (frame_done_o) n_fd++;
  endtask

  task automatic frame(int base, int maxgap);
    for (int k = 0; k < W * H; k++) begin
      int g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      for (int i = 0; i < g; i++) cyc(1'b0, 1'b0, 8'($urandom));
      cyc(1'b1, 1'b0, 8'(base + k));
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    pixel_valid_i = 1'b0;
    sof_i = 1'b0;
    model_reset();
    #1;
    chk("rst_win", window_o, 72'h0);
    chk("rst_valid", 72'(window_valid_o), 72'h0);
    chk("rst_done", 72'(frame_done_o), 72'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_std(string tag, int base);
    chk({tag, "_count"}, 72'(seen.size()), 72'(4));
    if (seen.size() == 4) begin
      chk({tag, "_w0"}, seen[0], lit(base + 0));
      chk({tag, "_w1"}, seen[1], lit(base + 1));
      chk({tag, "_w2"}, seen[2], lit(base + 4));
      chk({tag, "_w3"}, seen[3], lit(base + 5));
    end
    chk({tag, "_fd"}, 72'(n_fd), 72'(1));
    seen.delete();
    n_fd = 0;
  endtask

  initial begin
    n_fd = 0;
    model_reset();
    @(negedge clk);
    pulse_reset();

    frame(0, 0);
    expect_std("cont", 0);

    frame(0, 3);
    expect_std("gaps", 0);

    frame(0, 0);
    seen.delete(); n_fd = 0;
    frame(100, 0);
    expect_std("b2b", 100);

    for (int k = 0; k < 9; k++) cyc(1'b1, 1'b0, 8'(k));
    cyc(1'b0, 1'b1, 8'hee);
    seen.delete(); n_fd = 0;
    cyc(1'b1, 1'b1, 8'(50));
    for (int k = 1; k < 10; k++) cyc(1'b1, 1'b0, 8'(50 + k));
    chk("sof_nowin", 72'(seen.size()), 72'(0));
    for (int k = 10; k < 16; k++) cyc(1'b1, 1'b0, 8'(50 + k));
    expect_std("sof", 50);

    for (int k = 0; k < 13; k++) cyc(1'b1, 1'b0, 8'(k));
    seen.delete(); n_fd = 0;
    pulse_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h0);
    chk("rst_nowin", 72'(seen.size()), 72'(0));
    frame(0, 0);
    expect_std("rst", 0);

    for (int n = 0; n < 400; n++) begin
      bit v = ($urandom_range(3, 0) != 0);
      bit s = ($urandom_range(24, 0) == 0);
      cyc(v, s, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
